// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered ALU with valid/ready handshakes
//
// Purpose
//   Registered successor to the combinational processor ALU. Single-cycle ops
//   (ADD, SUB, LT, LE, bitwise logic, illegal codes) produce a result one edge
//   after acceptance. MUL is computed iteratively (radix-2 shift-add). DIV is
//   radix-2 restoring division and exists only when the optional feature is
//   enabled. Both take BITS cycles.
//
// Control-code scheme
//   ctl[3:2]=00 arithmetic, ctl[3:2]=01 compare, ctl[3]=1 bitwise logic.
//
// Optional feature
//   ALU_SEQ_DIV_EN : when defined, CMD_DIV is implemented. When undefined,
//                    no divider logic is built and CMD_DIV is an illegal code.
//
// Handshake
//   A command is accepted on a rising edge where in_valid & in_ready. A result
//   is consumed on a rising edge where out_valid & out_ready. While out_valid
//   is high and out_ready is low, out_lo/out_hi/flags stay stable.
//   in_ready = (state==IDLE) & (!out_valid | out_ready), and 0 during reset.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   operands/command valid
//   in_ready    out  block can accept a command
//   ctl         in   command code [CBITS-1:0]
//   a, b        in   operands [BITS-1:0]
//   out_valid   out  result valid
//   out_ready   in   consumer accepts the result
//   out_lo      out  result; quotient for DIV
//   out_hi      out  MUL upper half; DIV remainder; 0 otherwise
//   flag_zero   out  out_lo == 0
//   flag_ovf    out  signed overflow on ADD/SUB
//   flag_err    out  illegal opcode or divide by zero
//   dbg_state_o out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int               BITS     = 32,
    parameter int               CBITS    = 4,
    parameter logic [CBITS-1:0] CMD_ADD  = 4'b0000,
    parameter logic [CBITS-1:0] CMD_SUB  = 4'b0001,
    parameter logic [CBITS-1:0] CMD_MUL  = 4'b0010,
    parameter logic [CBITS-1:0] CMD_DIV  = 4'b0011,
    parameter logic [CBITS-1:0] CMD_LT   = 4'b0100,
    parameter logic [CBITS-1:0] CMD_LE   = 4'b0101,
    parameter logic [CBITS-1:0] CMD_AND  = 4'b1000,
    parameter logic [CBITS-1:0] CMD_OR   = 4'b1001,
    parameter logic [CBITS-1:0] CMD_XOR  = 4'b1010,
    parameter logic [CBITS-1:0] CMD_NAND = 4'b1011,
    parameter logic [CBITS-1:0] CMD_NOR  = 4'b1100,
    parameter logic [CBITS-1:0] CMD_NXOR = 4'b1101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CBITS-1:0] ctl,
    input  logic [BITS-1:0]  a,
    input  logic [BITS-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_lo,
    output logic [BITS-1:0]  out_hi,
    output logic             flag_zero,
    output logic             flag_ovf,
    output logic             flag_err,
    output logic [1:0]       dbg_state_o
);

    localparam int CW  = $clog2(BITS);
    localparam int MSB = BITS - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Iterative datapath: hi_q is the partial product / partial remainder,
    // lo_q is the multiplier being shifted out / dividend turning into the
    // quotient, opnd_q is the multiplicand / divisor.
    logic [BITS-1:0] hi_q, hi_d;
    logic [BITS-1:0] lo_q, lo_d;
    logic [BITS-1:0] opnd_q, opnd_d;

    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_lo_q, out_lo_d;
    logic [BITS-1:0] out_hi_q, out_hi_d;
    logic            flag_zero_q, flag_zero_d;
    logic            flag_ovf_q, flag_ovf_d;
    logic            flag_err_q, flag_err_d;

`ifdef ALU_SEQ_DIV_EN
    logic            is_div_q, is_div_d;
    logic            dz_q, dz_d;
    logic            start_div;
    logic [BITS:0]   div_shl;
    logic [BITS:0]   div_trial;
`endif

    logic            accept;
    logic            start_multi;
    logic [BITS-1:0] sum, dif;
    logic [BITS:0]   cmp_diff;
    logic            lt, eq;
    logic [BITS-1:0] sc_lo;
    logic            sc_ovf, sc_err;
    logic [BITS:0]   mul_sum;
    logic [BITS-1:0] step_hi, step_lo;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign in_ready = rst_n & (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    // -------------------------------------------------------------------------
    // Single-cycle result and opcode decode
    // -------------------------------------------------------------------------
    always_comb begin
        sum      = a + b;
        dif      = a - b;
        // Sign-extended BITS+1 difference cannot wrap, so its MSB is the
        // signed less-than result for every operand pair.
        cmp_diff = {a[MSB], a} - {b[MSB], b};
        lt       = cmp_diff[BITS];
        eq       = (cmp_diff == '0);

        sc_lo       = '0;
        sc_ovf      = 1'b0;
        sc_err      = 1'b0;
        start_multi = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        start_div   = 1'b0;
`endif

        case (ctl)
            CMD_ADD: begin
                sc_lo  = sum;
                sc_ovf = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
            end
            CMD_SUB: begin
                sc_lo  = dif;
                // b' = ~b, so "sign a == sign b'" becomes "sign a != sign b".
                sc_ovf = (a[MSB] != b[MSB]) & (dif[MSB] != a[MSB]);
            end
            CMD_MUL: start_multi = 1'b1;
            CMD_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                start_multi = 1'b1;
                start_div   = 1'b1;
`else
                sc_err = 1'b1;
`endif
            end
            CMD_LT:   sc_lo = {{(BITS-1){1'b0}}, lt};
            CMD_LE:   sc_lo = {{(BITS-1){1'b0}}, lt | eq};
            CMD_AND:  sc_lo = a & b;
            CMD_OR:   sc_lo = a | b;
            CMD_XOR:  sc_lo = a ^ b;
            CMD_NAND: sc_lo = ~(a & b);
            CMD_NOR:  sc_lo = ~(a | b);
            CMD_NXOR: sc_lo = ~(a ^ b);
            default:  sc_err = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // One radix-2 iteration step
    // -------------------------------------------------------------------------
    always_comb begin
        // Shift-add: conditionally add the multiplicand to the upper half,
        // then shift the {carry, hi, lo} concatenation right by one.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        step_hi = mul_sum[BITS:1];
        step_lo = {mul_sum[0], lo_q[BITS-1:1]};
`ifdef ALU_SEQ_DIV_EN
        // Restoring division: shift the next dividend bit into the partial
        // remainder and keep the subtraction only if it did not go negative.
        // With a zero divisor every trial succeeds, so the quotient fills with
        // ones and the remainder collects the dividend, which is exactly the
        // required divide-by-zero result.
        div_shl   = {hi_q, lo_q[BITS-1]};
        div_trial = div_shl - {1'b0, opnd_q};
        if (is_div_q) begin
            step_hi = div_trial[BITS] ? div_shl[BITS-1:0] : div_trial[BITS-1:0];
            step_lo = {lo_q[BITS-2:0], ~div_trial[BITS]};
        end
`endif
    end

    // -------------------------------------------------------------------------
    // FSM next state and result registers
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;
        flag_zero_d = flag_zero_q;
        flag_ovf_d  = flag_ovf_q;
        flag_err_d  = flag_err_q;
`ifdef ALU_SEQ_DIV_EN
        is_div_d    = is_div_q;
        dz_d        = dz_q;
`endif
        // A held result is dropped once the consumer takes it; a result
        // written on the same edge overrides this below.
        out_valid_d = out_ready ? 1'b0 : out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (start_multi) begin
                        hi_d    = '0;
                        lo_d    = a;
                        opnd_d  = b;
                        cnt_d   = CW'(BITS - 1);
                        state_d = S_ITER;
`ifdef ALU_SEQ_DIV_EN
                        is_div_d = start_div;
                        dz_d     = start_div & (b == '0);
`endif
                    end else begin
                        out_lo_d    = sc_lo;
                        out_hi_d    = '0;
                        flag_zero_d = (sc_lo == '0);
                        flag_ovf_d  = sc_ovf;
                        flag_err_d  = sc_err;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_ITER: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_lo_d    = step_lo;
                    out_hi_d    = step_hi;
                    flag_zero_d = (step_lo == '0);
                    flag_ovf_d  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
                    flag_err_d  = dz_q;
`else
                    flag_err_d  = 1'b0;
`endif
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_valid_q & out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            out_valid_q <= 1'b0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            flag_zero_q <= 1'b0;
            flag_ovf_q  <= 1'b0;
            flag_err_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            is_div_q    <= 1'b0;
            dz_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            out_valid_q <= out_valid_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            flag_zero_q <= flag_zero_d;
            flag_ovf_q  <= flag_ovf_d;
            flag_err_q  <= flag_err_d;
`ifdef ALU_SEQ_DIV_EN
            is_div_q    <= is_div_d;
            dz_q        <= dz_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_lo      = out_lo_q;
    assign out_hi      = out_hi_q;
    assign flag_zero   = flag_zero_q;
    assign flag_ovf    = flag_ovf_q;
    assign flag_err    = flag_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W  = 32;
  localparam int RW = 2 * W + 3;  // {hi, lo, zero, ovf, err}

  localparam logic [3:0] C_ADD  = 4'h0;
  localparam logic [3:0] C_SUB  = 4'h1;
  localparam logic [3:0] C_MUL  = 4'h2;
  localparam logic [3:0] C_DIV  = 4'h3;
  localparam logic [3:0] C_LT   = 4'h4;
  localparam logic [3:0] C_LE   = 4'h5;
  localparam logic [3:0] C_AND  = 4'h8;
  localparam logic [3:0] C_OR   = 4'h9;
  localparam logic [3:0] C_XOR  = 4'hA;
  localparam logic [3:0] C_NAND = 4'hB;
  localparam logic [3:0] C_NOR  = 4'hC;
  localparam logic [3:0] C_NXOR = 4'hD;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -SMAX - 1;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic         flag_zero, flag_ovf, flag_err;
  logic [3:0]   ctl;
  logic [W-1:0] a, b, out_lo, out_hi;
  logic [1:0]   dbg_state;

  int checks;
  int errors;
  int n_results;
  logic sb_en;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         z;
    logic         o;
    logic         e;
  } vec_t;

  vec_t vecs[$];

  alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ctl        (ctl),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lo     (out_lo),
    .out_hi     (out_hi),
    .flag_zero  (flag_zero),
    .flag_ovf   (flag_ovf),
    .flag_err   (flag_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                        input logic z, input logic o, input logic e);
    return {hi, lo, z, o, e};
  endfunction

  function automatic logic [RW-1:0] cur();
    return {out_hi, out_lo, flag_zero, flag_ovf, flag_err};
  endfunction

  function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] hi, input logic [W-1:0] lo,
                              input logic z, input logic o, input logic e);
    vec_t v;
    v.ctl = c; v.a = x; v.b = y; v.hi = hi; v.lo = lo; v.z = z; v.o = o; v.e = e;
    return v;
  endfunction

  // Reference model: results from plain integer arithmetic on the operands.
  function automatic logic [RW-1:0] model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] lo, hi;
    logic         ovf, err;
    longint       sx, sy, s;
    logic [2*W-1:0] p;
    lo = '0; hi = '0; ovf = 1'b0; err = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (c)
      C_ADD: begin s = sx + sy; lo = x + y; ovf = (s > SMAX) || (s < SMIN); end
      C_SUB: begin s = sx - sy; lo = x - y; ovf = (s > SMAX) || (s < SMIN); end
      C_MUL: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; hi = p[2*W-1:W]; lo = p[W-1:0]; end
      C_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        if (y == 0) begin lo = '1; hi = x; err = 1'b1; end
        else begin lo = x / y; hi = x % y; end
`else
        err = 1'b1;
`endif
      end
      C_LT:   lo = (sx < sy) ? 1 : 0;
      C_LE:   lo = (sx <= sy) ? 1 : 0;
      C_AND:  lo = x & y;
      C_OR:   lo = x | y;
      C_XOR:  lo = x ^ y;
      C_NAND: lo = ~(x & y);
      C_NOR:  lo = ~(x | y);
      C_NXOR: lo = ~(x ^ y);
      default: err = 1'b1;
    endcase
    return {hi, lo, (lo == 0), ovf, err};
  endfunction

  function automatic logic [3:0] pick_ctl();
    int r;
    r = $urandom_range(0, 99);
    if (r < 6) return C_MUL;
    if (r < 10) return C_DIV;
    if (r < 20) return 4'($urandom_range(0, 15));
    case ($urandom_range(0, 9))
      0: return C_ADD;
      1: return C_SUB;
      2: return C_LT;
      3: return C_LE;
      4: return C_AND;
      5: return C_OR;
      6: return C_XOR;
      7: return C_NAND;
      8: return C_NOR;
      default: return C_NXOR;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_opnd();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return 1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return '1;
      default: return $urandom;
    endcase
  endfunction

  // Advance past the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (sb_en) begin
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %h want none", cur());
        end else begin
          check("sb_result", cur(), exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(ctl, a, b));
    end
  end

  // ---------------- multi-cycle sequence ----------------
  task automatic run_multi(input string name, input logic [3:0] c, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [RW-1:0] exp);
    int lat;
    bit busy_ok, hold_ok;
    logic [RW-1:0] held;
    step();
    out_ready = 1'b0;
    ctl = c; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    check1({name, "_in_ready_idle"}, in_ready, 1'b1);
    step();
    // Keep presenting junk while busy; it must not be taken.
    ctl = pick_ctl(); a = $urandom; b = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 3 * W) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
    check_int({name, "_latency"}, lat, W);
    check1({name, "_in_ready_busy"}, busy_ok, 1'b1);
    check({name, "_result"}, cur(), exp);
    held = cur();
    hold_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || in_ready || cur() !== held) hold_ok = 1'b0;
    end
    check1({name, "_hold"}, hold_ok, 1'b1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check1({name, "_in_ready_hold"}, in_ready, 1'b0);
    step();
    @(negedge clk);
    check1({name, "_valid_after"}, out_valid, 1'b0);
    check1({name, "_in_ready_after"}, in_ready, 1'b1);
  endtask

  // ---------------- main ----------------
  initial begin
    checks = 0; errors = 0; n_results = 0; sb_en = 1'b0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ctl = '0; a = '0; b = '0;

    // Table: single-cycle ops with hand-derived results.
    vecs.push_back(mk(C_ADD, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, 0));
    vecs.push_back(mk(C_ADD, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(C_SUB, 32'd5, 32'd5, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(C_SUB, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 1, 0));
    vecs.push_back(mk(C_SUB, 32'd3, 32'd5, 0, 32'hFFFFFFFE, 0, 0, 0));
    vecs.push_back(mk(C_LT, 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0, 0, 0));
    vecs.push_back(mk(C_LT, 32'h80000000, 32'h7FFFFFFF, 0, 32'h1, 0, 0, 0));
    vecs.push_back(mk(C_LT, 32'h7FFFFFFF, 32'h80000000, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(C_LE, 32'd3, 32'd3, 0, 32'h1, 0, 0, 0));
    vecs.push_back(mk(C_LE, 32'd4, 32'd3, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(C_AND, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, 0, 0));
    vecs.push_back(mk(C_OR, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0, 0, 0));
    vecs.push_back(mk(C_NXOR, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF00FF00F, 0, 0, 0));
    vecs.push_back(mk(C_AND, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(4'h6, 32'h12345678, 32'h9ABCDEF0, 0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(4'h7, 32'h1, 32'h1, 0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(4'hE, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(4'hF, 32'h5, 32'h6, 0, 32'h0, 1, 0, 1));
`ifndef ALU_SEQ_DIV_EN
    vecs.push_back(mk(C_DIV, 32'd100, 32'd7, 0, 32'h0, 1, 0, 1));
`endif

    // Reset state: all outputs low while reset is held.
    #1 rst_n = 1'b0;
    #2;
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", cur(), '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("rel_in_ready", in_ready, 1'b1);
    check1("rel_out_valid", out_valid, 1'b0);

    // Table-driven single-cycle vectors, latency 1.
    for (int i = 0; i < vecs.size(); i++) begin
      step();
      out_ready = 1'b1;
      ctl = vecs[i].ctl; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
      @(negedge clk);
      check1($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d", i), cur(),
            rec(vecs[i].hi, vecs[i].lo, vecs[i].z, vecs[i].o, vecs[i].e));
    end

    // Multi-cycle: latency, busy in_ready, backpressure hold.
    run_multi("mul_max2", C_MUL, 32'hFFFFFFFF, 32'h2, rec(32'h1, 32'hFFFFFFFE, 0, 0, 0));
    run_multi("mul_sq", C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, rec(32'hFFFFFFFE, 32'h1, 0, 0, 0));
    run_multi("mul_zero", C_MUL, 32'h0, 32'h12345, rec(32'h0, 32'h0, 1, 0, 0));
`ifdef ALU_SEQ_DIV_EN
    run_multi("div_100_7", C_DIV, 32'd100, 32'd7, rec(32'd2, 32'd14, 0, 0, 0));
    run_multi("div_by0", C_DIV, 32'd100, 32'd0, rec(32'd100, 32'hFFFFFFFF, 0, 0, 1));
    run_multi("div_small", C_DIV, 32'd3, 32'd9, rec(32'd3, 32'd0, 1, 0, 0));
`endif

    // Streaming: NAND, NOR, XOR on consecutive edges.
    step();
    out_ready = 1'b1; a = 32'hF0F0F0F0; b = 32'hFF00FF00;
    ctl = C_NAND; in_valid = 1'b1;
    @(negedge clk);
    check1("stream_rdy0", in_ready, 1'b1);
    step();
    ctl = C_NOR;
    @(negedge clk);
    check("stream_nand", {out_valid, cur()}, {1'b1, rec(0, 32'h0FFF0FFF, 0, 0, 0)});
    check1("stream_rdy1", in_ready, 1'b1);
    step();
    ctl = C_XOR;
    @(negedge clk);
    check("stream_nor", {out_valid, cur()}, {1'b1, rec(0, 32'h000F000F, 0, 0, 0)});
    check1("stream_rdy2", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_xor", {out_valid, cur()}, {1'b1, rec(0, 32'h0FF00FF0, 0, 0, 0)});

    // Single-cycle backpressure, then simultaneous consume and accept.
    step();
    out_ready = 1'b0; ctl = C_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    step();
    ctl = C_SUB; a = 32'd10; b = 32'd3;
    @(negedge clk);
    check("bp_first", {out_valid, in_ready, cur()}, {2'b10, rec(0, 32'd3, 0, 0, 0)});
    step();
    @(negedge clk);
    check("bp_held", {out_valid, in_ready, cur()}, {2'b10, rec(0, 32'd3, 0, 0, 0)});
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_rdy_back", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_replaced", {out_valid, cur()}, {1'b1, rec(0, 32'd7, 0, 0, 0)});
    step();
    @(negedge clk);
    check1("bp_drained", out_valid, 1'b0);

    // Reset in the middle of a multiply.
    step();
    out_ready = 1'b1; ctl = C_MUL; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {in_ready, out_valid, cur()}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("midrst_in_ready", in_ready, 1'b1);
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (out_valid || !in_ready) quiet = 1'b0;
      end
      check1("midrst_no_stale", quiet, 1'b1);
    end

    // Randomized traffic against the reference model.
    sb_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = 1'(($urandom_range(0, 1)));
      ctl = pick_ctl();
      a = pick_opnd();
      b = pick_opnd();
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    begin
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || out_valid) && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    check_int("sb_drained", exp_q.size(), 0);
    check1("sb_activity", (n_results > 100), 1'b1);
    sb_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
